// File: rtl/sram_1w1r_bypass_init.sv
// 1-write/1-read SRAM model with byte write mask, write-first same-address bypass,
// optional output register and a post-reset sequencer that clears the array.
`timescale 1ns/1ps
module sram_1w1r_bypass_init #(
  parameter int unsigned           DATA_WIDTH  = 72,
  parameter int unsigned           ADDR_WIDTH  = 4,
  parameter int unsigned           WMASK_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter bit                    OUT_REG     = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   csb0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid,
  output logic                   collision,
  output logic                   init_busy
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;

  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]   bit_en;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    wr_en, rd_en, collide;

  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_valid, s1_coll;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  assign init_busy = (state_q == ST_INIT);
  assign wr_en     = (state_q == ST_RUN) && !csb0;
  assign rd_en     = (state_q == ST_RUN) && !csb1;
  assign collide   = wr_en && rd_en && (addr0 == addr1);

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit_en
    assign bit_en[g] = wmask0[g / 8];
  end

  // Merged word serves both the array update and the write-first bypass path.
  assign wr_word = (mem[addr0] & ~bit_en) | (din0 & bit_en);
  assign rd_word = collide ? wr_word : mem[addr1];

  // Array has no reset; the sequencer clears it once reset is released.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[init_cnt_q] <= INIT_VALUE;
    end else if (wr_en) begin
      mem[addr0] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      s1_coll  <= collide;
      if (rd_en) begin
        s1_data <= rd_word;
      end
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_valid, s2_coll;

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
        s2_coll  <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        s2_coll  <= s1_coll;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign dout1       = s2_data;
    assign dout1_valid = s2_valid;
    assign collision   = s2_coll;
  end else begin : g_no_out_reg
    assign dout1       = s1_data;
    assign dout1_valid = s1_valid;
    assign collision   = s1_coll;
  end

endmodule
